// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and big-endian 64-bit bit length.
module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_final
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_EXTRA = 2'd2;

    logic [1:0]   r_state;
    logic [5:0]   r_idx;
    logic [63:0]  r_bitcnt;
    logic         r_extra;
    logic         r_extra_pad;
    logic         r_first_pend;
    logic [511:0] r_buf;
    logic         r_in_ready;
    logic         r_blk_valid;
    logic         r_blk_first;
    logic         r_blk_final;

    logic [1:0]   w_state_nxt;
    logic [5:0]   w_idx_nxt;
    logic [63:0]  w_bitcnt_nxt;
    logic         w_extra_nxt;
    logic         w_extra_pad_nxt;
    logic         w_first_pend_nxt;
    logic [511:0] w_buf_nxt;
    logic         w_in_ready_nxt;
    logic         w_blk_valid_nxt;
    logic         w_blk_first_nxt;
    logic         w_blk_final_nxt;

    logic         w_accept;
    logic         w_blk_done;
    logic         w_blk_hs;
    logic [63:0]  w_bitcnt_inc;
    logic [5:0]   w_idx_inc;
    logic [8:0]   w_byte_base;
    logic [8:0]   w_pad_base;

    // Byte-reverses the bit count so its MSB lands in block byte 56.
    function automatic logic [63:0] f_len_field(input logic [63:0] bits);
        logic [63:0] res;
        res = 64'h0;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = bits[8*(7-i) +: 8];
        end
        return res;
    endfunction

    assign w_accept     = in_valid & r_in_ready;
    assign w_blk_done   = w_accept & (in_last | (r_idx == 6'd63));
    assign w_blk_hs     = r_blk_valid & blk_ready;
    assign w_bitcnt_inc = r_bitcnt + 64'd8;
    assign w_idx_inc    = r_idx + 6'd1;
    assign w_byte_base  = {r_idx, 3'b000};
    assign w_pad_base   = {w_idx_inc, 3'b000};

    // Next-state and datapath computation for the FILL / EMIT / EXTRA machine.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_bitcnt_nxt     = r_bitcnt;
        w_extra_nxt      = r_extra;
        w_extra_pad_nxt  = r_extra_pad;
        w_first_pend_nxt = r_first_pend;
        w_buf_nxt        = r_buf;
        w_in_ready_nxt   = r_in_ready;
        w_blk_valid_nxt  = r_blk_valid;
        w_blk_first_nxt  = r_blk_first;
        w_blk_final_nxt  = r_blk_final;

        case (r_state)
            ST_FILL: begin
                w_in_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_buf_nxt[w_byte_base +: 8] = in_data;
                    w_bitcnt_nxt = w_bitcnt_inc;
                    w_idx_nxt    = w_idx_inc;
                end else begin
                    w_idx_nxt = r_idx;
                end

                // Bytes above the write index are already zero: the buffer is cleared on re-entry to FILL.
                if (w_accept && in_last) begin
                    if (r_idx != 6'd63) begin
                        w_buf_nxt[w_pad_base +: 8] = 8'h80;
                        w_extra_pad_nxt = 1'b0;
                    end else begin
                        w_extra_pad_nxt = 1'b1;
                    end
                    if (r_idx <= 6'd54) begin
                        w_buf_nxt[511:448] = f_len_field(w_bitcnt_inc);
                        w_blk_final_nxt    = 1'b1;
                        w_extra_nxt        = 1'b0;
                    end else begin
                        w_blk_final_nxt    = 1'b0;
                        w_extra_nxt        = 1'b1;
                    end
                end else begin
                    w_blk_final_nxt = 1'b0;
                    w_extra_nxt     = 1'b0;
                end

                if (w_blk_done) begin
                    w_state_nxt      = ST_EMIT;
                    w_blk_valid_nxt  = 1'b1;
                    w_blk_first_nxt  = r_first_pend;
                    w_first_pend_nxt = 1'b0;
                    w_in_ready_nxt   = 1'b0;
                end else begin
                    w_state_nxt      = ST_FILL;
                end
            end

            ST_EMIT: begin
                w_in_ready_nxt = 1'b0;
                if (w_blk_hs) begin
                    w_blk_valid_nxt = 1'b0;
                    if (r_extra) begin
                        w_state_nxt = ST_EXTRA;
                        w_extra_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = ST_FILL;
                        w_idx_nxt      = 6'd0;
                        w_buf_nxt      = 512'h0;
                        w_in_ready_nxt = 1'b1;
                    end
                    if (r_blk_final) begin
                        w_bitcnt_nxt     = 64'h0;
                        w_first_pend_nxt = 1'b1;
                    end else begin
                        w_bitcnt_nxt     = r_bitcnt;
                    end
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end

            ST_EXTRA: begin
                w_buf_nxt       = {f_len_field(r_bitcnt), 440'h0,
                                   (r_extra_pad ? 8'h80 : 8'h00)};
                w_extra_pad_nxt = 1'b0;
                w_state_nxt     = ST_EMIT;
                w_blk_valid_nxt = 1'b1;
                w_blk_first_nxt = 1'b0;
                w_blk_final_nxt = 1'b1;
                w_in_ready_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt      = ST_FILL;
                w_idx_nxt        = 6'd0;
                w_bitcnt_nxt     = 64'h0;
                w_extra_nxt      = 1'b0;
                w_extra_pad_nxt  = 1'b0;
                w_first_pend_nxt = 1'b1;
                w_buf_nxt        = 512'h0;
                w_in_ready_nxt   = 1'b0;
                w_blk_valid_nxt  = 1'b0;
                w_blk_first_nxt  = 1'b0;
                w_blk_final_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_idx        <= 6'd0;
            r_bitcnt     <= 64'h0;
            r_extra      <= 1'b0;
            r_extra_pad  <= 1'b0;
            r_first_pend <= 1'b1;
            r_buf        <= 512'h0;
            r_in_ready   <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_final  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_extra      <= w_extra_nxt;
            r_extra_pad  <= w_extra_pad_nxt;
            r_first_pend <= w_first_pend_nxt;
            r_buf        <= w_buf_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_blk_valid  <= w_blk_valid_nxt;
            r_blk_first  <= w_blk_first_nxt;
            r_blk_final  <= w_blk_final_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign blk_data  = r_buf;
    assign blk_valid = r_blk_valid;
    assign blk_first = r_blk_first;
    assign blk_final = r_blk_final;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: a queue-based padding model predicts every block,
// and a compare process checks each block handshake against it.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_final;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]   msg_q[$];
    logic [7:0]   pad_q[$];
    logic [511:0] exp_data_q[$];
    logic         exp_first_q[$];
    logic         exp_final_q[$];
    logic [511:0] last_blk;
    logic         last_first;
    logic         last_final;
    bit           bp_force = 1'b0;
    bit           gap_en   = 1'b0;

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_final (blk_final)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standard SHA-256 padding of the whole message, as a byte queue.
    task automatic model_pad();
        logic [63:0] bits;
        pad_q = msg_q;
        pad_q.push_back(8'h80);
        while ((pad_q.size() % 64) != 56) pad_q.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad_q.push_back(bits[8*i +: 8]);
    endtask

    function automatic logic [511:0] pad_block(input int b);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[8*i +: 8] = pad_q[64*b + i];
        return v;
    endfunction

    task automatic queue_blocks();
        int nb;
        model_pad();
        nb = pad_q.size() / 64;
        for (int b = 0; b < nb; b++) begin
            exp_data_q.push_back(pad_block(b));
            exp_first_q.push_back(b == 0);
            exp_final_q.push_back(b == nb - 1);
        end
    endtask

    task automatic make_rand(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic make_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_byte(input logic [7:0] d, input logic l);
        int t;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            t++;
            if (t >= 5000) begin
                n_chk++;
                n_err++;
                $display("FAIL push_timeout: in_ready stuck at %0b", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
    endtask

    task automatic send_msg();
        queue_blocks();
        for (int i = 0; i < msg_q.size(); i++) push_byte(msg_q[i], i == msg_q.size() - 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (exp_data_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d blocks still expected", exp_data_q.size());
            exp_data_q.delete();
            exp_first_q.delete();
            exp_final_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_blk_valid"}, blk_valid, 1'b0);
        check({tag, "_blk_first"}, blk_first, 1'b0);
        check({tag, "_blk_final"}, blk_final, 1'b0);
        check({tag, "_blk_data"},  blk_data,  512'h0);
    endtask

    // Random consumer backpressure unless a directed test owns blk_ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bp_force) blk_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: every block handshake against the model, plus hold stability.
    initial begin
        logic         hold;
        logic [511:0] hd;
        logic         hf, hl;
        hold = 1'b0;
        hd = '0; hf = 1'b0; hl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", blk_valid, 1'b1);
                    check("hold_data",  blk_data,  hd);
                    check("hold_first", blk_first, hf);
                    check("hold_final", blk_final, hl);
                end
                if (blk_valid === 1'b1) begin
                    check("emit_in_ready", in_ready, 1'b0);
                    if (blk_ready === 1'b1) begin
                        hold = 1'b0;
                        if (exp_data_q.size() == 0) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL unexpected_block: got %0h expected none", blk_data);
                        end else begin
                            check("blk_data",  blk_data,  exp_data_q.pop_front());
                            check("blk_first", blk_first, exp_first_q.pop_front());
                            check("blk_final", blk_final, exp_final_q.pop_front());
                        end
                        last_blk   = blk_data;
                        last_first = blk_first;
                        last_final = blk_final;
                    end else begin
                        hold = 1'b1;
                        hd = blk_data;
                        hf = blk_first;
                        hl = blk_final;
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] bp_data;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        blk_ready = 1'b0;
        last_blk = '0;
        last_first = 1'b0;
        last_final = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // "abc": model pinned to the hand-computed block, then the DUT.
        make_abc();
        model_pad();
        check("model_abc", pad_block(0), {8'h18, 472'h0, 32'h80636261});
        send_msg();
        wait_drain();
        check("dut_abc", last_blk, {8'h18, 472'h0, 32'h80636261});
        check("dut_abc_first", last_first, 1'b1);
        check("dut_abc_final", last_final, 1'b1);

        make_rand(55);
        model_pad();
        check("model55_size", pad_q.size(), 64);
        check("model55_b55", pad_q[55], 8'h80);
        check("model55_b62", pad_q[62], 8'h01);
        check("model55_b63", pad_q[63], 8'hB8);
        send_msg();
        wait_drain();
        check("dut55_first", last_first, 1'b1);
        check("dut55_final", last_final, 1'b1);

        make_rand(56);
        model_pad();
        check("model56_size", pad_q.size(), 128);
        check("model56_b56", pad_q[56], 8'h80);
        check("model56_b127", pad_q[127], 8'hC0);
        send_msg();
        wait_drain();
        check("dut56_blk2", last_blk, {8'hC0, 8'h01, 496'h0});
        check("dut56_first", last_first, 1'b0);
        check("dut56_final", last_final, 1'b1);

        make_rand(64);
        model_pad();
        check("model64_b64", pad_q[64], 8'h80);
        check("model64_b126", pad_q[126], 8'h02);
        send_msg();
        wait_drain();
        check("dut64_blk2", last_blk, {8'h00, 8'h02, 488'h0, 8'h80});
        check("dut64_final", last_final, 1'b1);

        // Backpressure: ready low for 10 cycles with a junk byte offered.
        bp_force = 1'b1;
        blk_ready = 1'b0;
        make_abc();
        send_msg();
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        bp_data  = blk_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", blk_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_data", blk_data, bp_data);
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        bp_force  = 1'b0;
        @(negedge clk);
        check("bp_in_ready_after_hs", in_ready, 1'b1);
        check("bp_valid_after_hs", blk_valid, 1'b0);
        wait_drain();

        // Reset mid-message discards 30 bytes; the next message starts fresh.
        make_rand(30);
        for (int i = 0; i < 30; i++) push_byte(msg_q[i], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_mid_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;
        make_abc();
        send_msg();
        wait_drain();
        check("dut_abc_after_rst", last_blk, {8'h18, 472'h0, 32'h80636261});
        check("dut_abc_after_rst_first", last_first, 1'b1);
        make_abc();
        send_msg();
        make_abc();
        send_msg();
        wait_drain();
        check("dut_abc2_first", last_first, 1'b1);
        check("dut_abc2_final", last_final, 1'b1);

        // Random messages, back to back, with input gaps and random backpressure.
        gap_en = 1'b1;
        for (int m = 0; m < 40; m++) begin
            make_rand($urandom_range(1, 150));
            send_msg();
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
